// File: rtl/fb_arbiter_pkg.sv
// Shared defaults, swap FSM encoding and derived framebuffer geometry for the
// framebuffer arbiter and anything that addresses the downscaled framebuffer.
package fb_arbiter_pkg;

    localparam int H_RES_DEFAULT  = 800;
    localparam int V_RES_DEFAULT  = 600;
    localparam int SCALE_DEFAULT  = 2;
    localparam int FB_AW_DEFAULT  = 15;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        SWAP_IDLE = 1'b0,
        SWAP_PEND = 1'b1
    } swap_state_t;

    function automatic int fb_width(input int h_res, input int scale);
        return h_res >> scale;
    endfunction

    function automatic int fb_pixels(input int h_res, input int v_res, input int scale);
        return (h_res >> scale) * (v_res >> scale);
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Maps a full-resolution screen coordinate to a linear pixel address inside one
// downscaled framebuffer. Purely combinational; also used by the drawing engine.
module fb_addr_gen
    import fb_arbiter_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT,
    parameter int SCALE = SCALE_DEFAULT,
    parameter int FB_AW = FB_AW_DEFAULT
) (
    input  logic [10:0]      i_x,
    input  logic [9:0]       i_y,
    output logic [FB_AW-1:0] o_addr
);

    localparam int FB_W = fb_width(H_RES, SCALE);

    logic [FB_AW-1:0] row;
    logic [FB_AW-1:0] col;

    always_comb begin
        row    = FB_AW'(i_y >> SCALE);
        col    = FB_AW'(i_x >> SCALE);
        o_addr = (row * FB_AW'(FB_W)) + col;
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port video RAM arbiter: display fetch has absolute priority over
// drawing-engine writes, and front/back buffers flip at the end of a frame.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int H_RES         = H_RES_DEFAULT,
    parameter int V_RES         = V_RES_DEFAULT,
    parameter int SCALE         = SCALE_DEFAULT,
    parameter int FB_AW         = FB_AW_DEFAULT,
    parameter int DATA_W        = DATA_W_DEFAULT,
    parameter int WR_BLANK_ONLY = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_stb,
    input  logic              i_active,
    input  logic              i_animate,
    input  logic [10:0]       i_x,
    input  logic [9:0]        i_y,
    input  logic              i_wr_req,
    input  logic [FB_AW-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    output logic              o_wr_err,
    input  logic              i_swap_req,
    output logic              o_swap_pending,
    output logic              o_swap_done,
    output logic              o_disp_buf,
    output logic [FB_AW:0]    o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_valid
);

    localparam int             FB_PIXELS     = fb_pixels(H_RES, V_RES, SCALE);
    localparam logic [FB_AW:0] FB_PIX_LIMIT  = (FB_AW+1)'(FB_PIXELS);
    localparam logic           BLANK_GATE    = (WR_BLANK_ONLY != 0);

    logic             disp_rd;
    logic             wr_grant;
    logic             wr_in_range;
    logic [FB_AW-1:0] rd_pix_addr;
    swap_state_t      state;
    swap_state_t      state_next;
    logic             swap_apply;
    logic             s1_valid;
    logic             s1_read;

    fb_addr_gen #(
        .H_RES (H_RES),
        .SCALE (SCALE),
        .FB_AW (FB_AW)
    ) u_addr_gen (
        .i_x    (i_x),
        .i_y    (i_y),
        .o_addr (rd_pix_addr)
    );

    // Port ownership decided combinationally so read address and write strobe
    // reach the RAM in the same cycle as the request.
    always_comb begin
        disp_rd     = i_pix_stb & i_active & ~i_rst;
        wr_grant    = i_wr_req & ~disp_rd & ~i_rst & (~BLANK_GATE | ~i_active);
        wr_in_range = ({1'b0, i_wr_addr} < FB_PIX_LIMIT);
        o_wr_ack    = wr_grant;
        o_wr_err    = wr_grant & ~wr_in_range;
        o_ram_we    = wr_grant & wr_in_range;
        o_ram_wdata = o_ram_we ? i_wr_data : '0;
        if (disp_rd) begin
            o_ram_addr = {o_disp_buf, rd_pix_addr};
        end else begin
            o_ram_addr = {~o_disp_buf, i_wr_addr};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= SWAP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        swap_apply = 1'b0;
        case (state)
            SWAP_IDLE: begin
                if (i_swap_req) begin
                    state_next = SWAP_PEND;
                end
            end
            SWAP_PEND: begin
                if (i_animate & i_pix_stb) begin
                    state_next = SWAP_IDLE;
                    swap_apply = 1'b1;
                end
            end
            default: state_next = SWAP_IDLE;
        endcase
    end

    always_comb begin
        o_swap_pending = (state == SWAP_PEND);
    end

    // The flip lands one clock after the apply cycle, so that cycle's own
    // read and write still use the old buffer assignment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_disp_buf  <= 1'b0;
            o_swap_done <= 1'b0;
        end else begin
            o_swap_done <= swap_apply;
            if (swap_apply) begin
                o_disp_buf <= ~o_disp_buf;
            end
        end
    end

    // Two-stage token pipeline matching the RAM's one-clock read latency;
    // blank-time strobes still emit a valid, carrying zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid    <= 1'b0;
            s1_read     <= 1'b0;
            o_pix_valid <= 1'b0;
            o_pix_data  <= '0;
        end else begin
            s1_valid    <= i_pix_stb;
            s1_read     <= disp_rd;
            o_pix_valid <= s1_valid;
            if (s1_valid) begin
                o_pix_data <= s1_read ? i_ram_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized scoreboard bench for fb_arbiter: two instances (free writes and
// blank-only writes) share stimulus, each backed by its own RAM and reference framebuffer.
module tb_fb_arbiter;

    localparam int FB_AW     = 15;
    localparam int DATA_W    = 8;
    localparam int FB_W      = 200;
    localparam int FB_PIXELS = 30000;
    localparam int N_RANDOM  = 3000;

    typedef struct {
        int               due;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              pix_stb;
    logic              active;
    logic              animate;
    logic [10:0]       x;
    logic [9:0]        y;
    logic              wr_req;
    logic [FB_AW-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              swap_req;

    logic              wr_ack       [2];
    logic              wr_err       [2];
    logic              swap_pending [2];
    logic              swap_done    [2];
    logic              disp_buf     [2];
    logic              ram_we       [2];
    logic              pix_valid    [2];
    logic [FB_AW:0]    ram_addr     [2];
    logic [DATA_W-1:0] ram_wdata    [2];
    logic [DATA_W-1:0] ram_rdata    [2];
    logic [DATA_W-1:0] pix_data     [2];

    logic [DATA_W-1:0] ram0 [65536] = '{default: '0};
    logic [DATA_W-1:0] ram1 [65536] = '{default: '0};
    logic [DATA_W-1:0] model_fb [2][65536] = '{default: '{default: '0}};

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    logic chk_en       = 1'b0;
    logic prev_stb     = 1'b0;
    bit   m_pending    = 1'b0;
    bit   m_disp       = 1'b0;
    bit   m_done       = 1'b0;
    exp_t exp_q [$];
    logic [DATA_W-1:0] last_pix [2] = '{default: '0};

    fb_arbiter #(.WR_BLANK_ONLY(0)) dut_free (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_active(active),
        .i_animate(animate), .i_x(x), .i_y(y), .i_wr_req(wr_req),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack[0]),
        .o_wr_err(wr_err[0]), .i_swap_req(swap_req), .o_swap_pending(swap_pending[0]),
        .o_swap_done(swap_done[0]), .o_disp_buf(disp_buf[0]), .o_ram_addr(ram_addr[0]),
        .o_ram_we(ram_we[0]), .o_ram_wdata(ram_wdata[0]), .i_ram_rdata(ram_rdata[0]),
        .o_pix_data(pix_data[0]), .o_pix_valid(pix_valid[0])
    );

    fb_arbiter #(.WR_BLANK_ONLY(1)) dut_blank (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_active(active),
        .i_animate(animate), .i_x(x), .i_y(y), .i_wr_req(wr_req),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack[1]),
        .o_wr_err(wr_err[1]), .i_swap_req(swap_req), .o_swap_pending(swap_pending[1]),
        .o_swap_done(swap_done[1]), .o_disp_buf(disp_buf[1]), .o_ram_addr(ram_addr[1]),
        .o_ram_we(ram_we[1]), .o_ram_wdata(ram_wdata[1]), .i_ram_rdata(ram_rdata[1]),
        .o_pix_data(pix_data[1]), .o_pix_valid(pix_valid[1])
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we[0]) ram0[ram_addr[0]] <= ram_wdata[0];
        if (ram_we[1]) ram1[ram_addr[1]] <= ram_wdata[1];
        ram_rdata[0] <= ram0[ram_addr[0]];
        ram_rdata[1] <= ram1[ram_addr[1]];
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h",
                     name, inst, cyc, actual, expected);
        end
    endtask

    // Reference: arbitration rules, framebuffer contents and swap state at frame level.
    task automatic modelStep();
        logic             d;
        logic             w;
        logic             in_range;
        logic [FB_AW-1:0] pix;
        int               rd_idx;
        int               wr_idx;
        exp_t             e;
        d        = pix_stb & active & ~rst;
        pix      = FB_AW'((int'(y) / 4) * FB_W + int'(x) / 4);
        in_range = (int'(wr_addr) < FB_PIXELS);
        rd_idx   = (m_disp ? 32768 : 0) + int'(pix);
        wr_idx   = (m_disp ? 0 : 32768) + int'(wr_addr);
        if (pix_stb && !rst) begin
            e.due = cyc + 2;
            e.d0  = d ? model_fb[0][rd_idx] : '0;
            e.d1  = d ? model_fb[1][rd_idx] : '0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 2; i++) begin
            w = wr_req & ~d & ~rst & (i == 0 || !active);
            checkOutput("wr_ack", i, wr_ack[i], w);
            checkOutput("wr_err", i, wr_err[i], w & ~in_range);
            checkOutput("ram_we", i, ram_we[i], w & in_range);
            checkOutput("disp_buf", i, disp_buf[i], m_disp);
            checkOutput("swap_pending", i, swap_pending[i], m_pending);
            checkOutput("swap_done", i, swap_done[i], m_done);
            if (d) checkOutput("rd_addr", i, ram_addr[i], {m_disp, pix});
            if (w) checkOutput("wr_addr", i, ram_addr[i], {~m_disp, wr_addr});
            if (w && in_range) begin
                checkOutput("ram_wdata", i, ram_wdata[i], wr_data);
                model_fb[i][wr_idx] = wr_data;
            end
        end
        if (rst) begin
            while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
            m_pending = 1'b0;
            m_disp    = 1'b0;
            m_done    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_pending && animate && pix_stb) begin
                m_disp    = ~m_disp;
                m_pending = 1'b0;
                m_done    = 1'b1;
            end else if (!m_pending && swap_req) begin
                m_pending = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic stb, input logic act,
                                 input logic anim, input int xi, input int yi,
                                 input logic req, input int wa, input int wd,
                                 input logic sreq);
        rst      = r;
        pix_stb  = stb & ~prev_stb;
        active   = act;
        animate  = anim;
        x        = 11'(xi);
        y        = 10'(yi);
        wr_req   = req;
        wr_addr  = FB_AW'(wa);
        wr_data  = DATA_W'(wd);
        swap_req = sreq;
        prev_stb = pix_stb;
        @(negedge clk);
        if (chk_en) modelStep();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation whenever a pixel is due, otherwise demands
    // that valid stays low and the last pixel value is held.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                checkOutput("pix_valid", 0, pix_valid[0], 1'b1);
                checkOutput("pix_valid", 1, pix_valid[1], 1'b1);
                checkOutput("pix_data", 0, pix_data[0], e.d0);
                checkOutput("pix_data", 1, pix_data[1], e.d1);
                last_pix[0] = e.d0;
                last_pix[1] = e.d1;
            end else begin
                checkOutput("pix_idle", 0, pix_valid[0], 1'b0);
                checkOutput("pix_idle", 1, pix_valid[1], 1'b0);
                checkOutput("pix_hold", 0, pix_data[0], last_pix[0]);
                checkOutput("pix_hold", 1, pix_data[1], last_pix[1]);
            end
            if (rst) begin
                last_pix[0] = '0;
                last_pix[1] = '0;
            end
        end
    end

    initial begin
        logic act_r;
        int   xi, yi, wa, sel;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;

        applyStimulus(1, 1, 1, 0, 4, 4, 1, 100, 8'h11, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 201, 8'hA5, 0);
        applyStimulus(0, 1, 1, 0, 4, 4, 1, 100, 8'h3C, 0);
        applyStimulus(0, 0, 1, 0, 4, 4, 1, 100, 8'h3C, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 30000, 8'h77, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 0, 0, 1, 5, 8'h42, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 8'h43, 0);
        applyStimulus(0, 1, 1, 0, 4, 4, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 7, 8'h99, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 7, 8'h99, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 8'h99, 0);
        applyStimulus(0, 1, 1, 0, 8, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        act_r = 1'b1;
        for (int n = 0; n < N_RANDOM; n++) begin
            if ($urandom_range(7) == 0) act_r = ~act_r;
            xi  = ($urandom_range(9) == 0) ? int'($urandom_range(799)) : int'($urandom_range(15));
            yi  = ($urandom_range(9) == 0) ? int'($urandom_range(599)) : int'($urandom_range(15));
            sel = int'($urandom_range(19));
            if (sel < 14)      wa = int'($urandom_range(3)) * FB_W + int'($urandom_range(3));
            else if (sel < 17) wa = int'($urandom_range(32767, 30000));
            else               wa = int'($urandom_range(29999));
            applyStimulus($urandom_range(59) == 0, $urandom_range(1) == 1, act_r,
                          $urandom_range(15) == 0, xi, yi, $urandom_range(2) != 0,
                          wa, int'($urandom_range(255)), $urandom_range(5) == 0);
        end

        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("queue_drained", 0, exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
